// File: rtl/converters_pkg.sv
// Shared definitions for the converter blocks: FSM state encodings and the
// minimum legal word width.
package converters_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam int MIN_N = 2;

endpackage

// File: rtl/twos_to_sign_mag_serial_if.sv
// Word-in / result-out handshake bundle for the serial sign-magnitude converter.
interface twos_to_sign_mag_serial_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sign;
  logic [N-1:0] out_mag;
  logic         out_min;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_min
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_min
  );
endinterface

// File: rtl/serial_negate_cell.sv
// One-bit LSB-first negation step: pass bits through until the first 1 has gone
// by, then invert. With neg low the bit passes unchanged.
module serial_negate_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic neg,
  input  logic b_in,
  output logic r_out
);
  logic seen_one;

  always_ff @(posedge clk) begin
    if (rst)      seen_one <= 1'b0;
    else if (clr) seen_one <= 1'b0;
    else if (en)  seen_one <= seen_one | b_in;
  end

  // seen_one reflects only earlier bits, so the first 1 itself is copied.
  assign r_out = neg ? (b_in ^ seen_one) : b_in;
endmodule

// File: rtl/twos_to_sign_mag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter: accepts a word in IDLE,
// shifts it LSB-first through the negate cell for N cycles, presents it in DONE.
module twos_to_sign_mag_serial
  import converters_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  twos_to_sign_mag_serial_if.slave      bus,
  output logic                          busy
);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0]     MIN_WORD = {1'b1, {(N-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N-1);

  generate
    if (N < MIN_N) begin : g_bad_n
      $error("twos_to_sign_mag_serial: N must be >= %0d", MIN_N);
    end
  endgenerate

  conv_state_t      state, state_d;
  logic [N-1:0]     sr, mag_q;
  logic [CNT_W-1:0] cnt;
  logic             sign_q, min_q;
  logic             accept, shift_en, r;

  always_comb begin
    state_d      = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    busy         = 1'b0;
    accept       = 1'b0;
    shift_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sr     <= '0;
      cnt    <= '0;
      mag_q  <= '0;
      sign_q <= 1'b0;
      min_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        sr     <= bus.in_data;
        sign_q <= bus.in_data[N-1];
        min_q  <= (bus.in_data == MIN_WORD);
        cnt    <= '0;
        mag_q  <= '0;
      end else if (shift_en) begin
        sr    <= sr >> 1;
        mag_q <= {r, mag_q[N-1:1]};
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  serial_negate_cell u_neg (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (shift_en),
    .neg   (sign_q),
    .b_in  (sr[0]),
    .r_out (r)
  );

  assign bus.out_sign = sign_q;
  assign bus.out_mag  = mag_q;
  assign bus.out_min  = min_q;
endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
// Scoreboard bench: directed N=4 vectors plus an N=8 full sweep; monitors pop
// expected results whenever a result is handed off.
module tb_twos_to_sign_mag_serial;
  typedef struct {
    logic       s;
    logic [7:0] m;
    logic       mn;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy4, busy8;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  twos_to_sign_mag_serial_if #(.N(4)) b4();
  twos_to_sign_mag_serial_if #(.N(8)) b8();

  twos_to_sign_mag_serial #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave), .busy(busy4));
  twos_to_sign_mag_serial #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave), .busy(busy8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) chk("n4 unexpected result", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        chk("n4 result {sign,mag,min}", {26'd0, b4.out_sign, b4.out_mag, b4.out_min},
            {26'd0, e.s, e.m[3:0], e.mn});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b8.out_valid && b8.out_ready) begin
      if (q8.size() == 0) chk("n8 unexpected result", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("n8 result {sign,mag,min}", {22'd0, b8.out_sign, b8.out_mag, b8.out_min},
            {22'd0, e.s, e.m, e.mn});
      end
    end
  end

  task automatic send4(input logic [3:0] d, input logic s, input logic [3:0] m,
                       input logic mn, input int hold);
    int   lat;
    bit   acc;
    exp_t e;
    e.s = s; e.m = {4'd0, m}; e.mn = mn;
    b4.in_data = d; b4.in_valid = 1'b1; b4.out_ready = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = b4.in_ready;
      @(posedge clk);
    end
    #1 b4.in_valid = 1'b0;
    if (!acc) begin
      chk("n4 accept timeout", 32'd0, 32'd1);
      return;
    end
    q4.push_back(e);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (b4.out_valid) begin lat = i; break; end
    end
    chk("n4 latency", lat, 32'd4);
    for (int i = 0; i < hold; i++) begin
      chk("n4 hold out_valid", {31'd0, b4.out_valid}, 32'd1);
      chk("n4 hold in_ready", {31'd0, b4.in_ready}, 32'd0);
      chk("n4 hold value", {26'd0, b4.out_sign, b4.out_mag, b4.out_min}, {26'd0, s, m, mn});
      b4.in_valid = i[0];
      b4.in_data  = 4'b0011;
      @(posedge clk); #1;
    end
    b4.in_valid = 1'b0; b4.out_ready = 1'b1;
    @(posedge clk); #1 b4.out_ready = 1'b0;
    chk("n4 idle after handoff", {31'd0, b4.in_ready}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t       e;
    bit         acc;
    int         n, lat;
    int         t[2];
    logic [7:0] xv, mg;

    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset in_ready", {31'd0, b4.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, b4.out_valid}, 32'd0);
    chk("reset busy", {31'd0, busy4}, 32'd0);
    chk("reset outputs", {26'd0, b4.out_sign, b4.out_mag, b4.out_min}, 32'd0);

    send4(4'b0101, 1'b0, 4'b0101, 1'b0, 0);
    send4(4'b1010, 1'b1, 4'b0110, 1'b0, 5);
    send4(4'b1000, 1'b1, 4'b1000, 1'b1, 0);
    send4(4'b0000, 1'b0, 4'b0000, 1'b0, 0);

    // back-to-back words with out_ready held high
    e.s = 1'b1; e.m = 8'h01; e.mn = 1'b0; q4.push_back(e);
    e.s = 1'b0; e.m = 8'h07; e.mn = 1'b0; q4.push_back(e);
    b4.out_ready = 1'b1; b4.in_data = 4'b1111; b4.in_valid = 1'b1;
    n = 0; t[0] = 0; t[1] = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge clk); acc = b4.in_valid && b4.in_ready;
      @(posedge clk);
      if (acc) begin
        t[n] = c; n++;
        #1 b4.in_data = 4'b0111;
        if (n == 2) b4.in_valid = 1'b0;
      end
    end
    chk("b2b accept count", n, 32'd2);
    chk("b2b accept spacing", t[1] - t[0], 32'd6);
    for (int c = 0; c < 20 && q4.size() != 0; c++) @(posedge clk);
    #1 b4.out_ready = 1'b0;
    chk("b2b results drained", q4.size(), 32'd0);

    // reset in the middle of SHIFT
    @(posedge clk); #1;
    b4.in_data = 4'b1011; b4.in_valid = 1'b1;
    @(negedge clk); chk("abort word accepted", {31'd0, b4.in_ready}, 32'd1);
    @(posedge clk); #1 b4.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort in_ready", {31'd0, b4.in_ready}, 32'd1);
    chk("abort out_valid", {31'd0, b4.out_valid}, 32'd0);
    chk("abort busy", {31'd0, busy4}, 32'd0);
    send4(4'b1101, 1'b1, 4'b0011, 1'b0, 0);

    // N=8 sweep
    b8.out_ready = 1'b1;
    for (int x = 0; x < 256; x++) begin
      xv = x[7:0];
      mg = xv[7] ? (~xv + 8'd1) : xv;
      e.s = xv[7]; e.m = mg; e.mn = (xv == 8'h80);
      b8.in_data = xv; b8.in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
        @(negedge clk); acc = b8.in_ready;
        @(posedge clk);
      end
      #1 b8.in_valid = 1'b0;
      if (!acc) begin
        chk("n8 accept timeout", 32'd0, 32'd1);
        break;
      end
      q8.push_back(e);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk); #1;
        if (b8.out_valid) begin lat = i; break; end
      end
      chk("n8 latency", lat, 32'd8);
      @(posedge clk); #1;
    end
    b8.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    chk("scoreboard empty", q4.size() + q8.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
